// File: rtl/data_memory_stage.sv
// Data memory stage: issues cache requests for loads/stores, steers store lanes,
// extracts and extends load data, and registers the write-back payload.
module data_memory_stage (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [4:0]  RD_ADDRESS_IN,
  input  logic [31:0] ALU_OUT_IN,
  input  logic [2:0]  DATA_CACHE_LOAD_IN,
  input  logic [1:0]  DATA_CACHE_STORE_IN,
  input  logic [31:0] DATA_CACHE_STORE_DATA_IN,
  input  logic        WRITE_BACK_MUX_SELECT_IN,
  input  logic        RD_WRITE_ENABLE_IN,
  output logic        CACHE_REQ_VALID,
  input  logic        CACHE_REQ_READY,
  output logic        CACHE_REQ_WRITE,
  output logic [31:0] CACHE_ADDRESS,
  output logic [3:0]  CACHE_WRITE_STROBE,
  output logic [31:0] CACHE_WRITE_DATA,
  input  logic        CACHE_RESP_VALID,
  input  logic [31:0] CACHE_RESP_DATA,
  output logic        STALL_REQUEST,
  output logic [4:0]  RD_ADDRESS_OUT,
  output logic [31:0] RD_DATA_OUT,
  output logic        RD_WRITE_ENABLE_OUT,
  output logic        MISALIGNED_EXCEPTION
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned STRB_W = 4;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LW   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    REQUEST       = 2'd1,
    WAIT_RESPONSE = 2'd2
  } state_t;

  state_t state, state_next;

  // Captured memory operation, held stable for the whole access
  logic [2:0]        op_load,   op_load_next;
  logic              op_write,  op_write_next;
  logic [XLEN-1:0]   op_addr,   op_addr_next;
  logic [STRB_W-1:0] op_strobe, op_strobe_next;
  logic [XLEN-1:0]   op_data,   op_data_next;
  logic              op_wb_sel, op_wb_sel_next;
  logic [REG_W-1:0]  op_rd,     op_rd_next;
  logic              op_we,     op_we_next;

  logic [REG_W-1:0]  rd_address_next;
  logic [XLEN-1:0]   rd_data_next;
  logic              rd_we_next;
  logic              misaligned_next;

  logic [2:0]        load_op_c;
  logic [1:0]        store_op_c;
  logic              misaligned_c;
  logic [STRB_W-1:0] strobe_c;
  logic [XLEN-1:0]   wdata_c;
  logic [7:0]        lane_byte_c;
  logic [15:0]       lane_half_c;
  logic [XLEN-1:0]   load_data_c;
  logic [XLEN-1:0]   result_c;

  // Decode incoming op: undefined load codes are no-ops, a load overrides a store
  always_comb begin
    load_op_c  = (DATA_CACHE_LOAD_IN >= LD_LB && DATA_CACHE_LOAD_IN <= LD_LHU) ?
                 DATA_CACHE_LOAD_IN : LD_NONE;
    store_op_c = (load_op_c != LD_NONE) ? ST_NONE : DATA_CACHE_STORE_IN;
    misaligned_c = LOW;
    if ((load_op_c == LD_LH || load_op_c == LD_LHU || store_op_c == ST_SH) && ALU_OUT_IN[0])
      misaligned_c = HIGH;
    if ((load_op_c == LD_LW || store_op_c == ST_SW) && (ALU_OUT_IN[1:0] != 2'b00))
      misaligned_c = HIGH;
  end

  // Store byte-lane steering
  always_comb begin
    strobe_c = '0;
    wdata_c  = '0;
    case (store_op_c)
      ST_SB: begin
        strobe_c = 4'b0001 << ALU_OUT_IN[1:0];
        wdata_c  = {4{DATA_CACHE_STORE_DATA_IN[7:0]}};
      end
      ST_SH: begin
        strobe_c = 4'b0011 << {ALU_OUT_IN[1], 1'b0};
        wdata_c  = {2{DATA_CACHE_STORE_DATA_IN[15:0]}};
      end
      ST_SW: begin
        strobe_c = 4'b1111;
        wdata_c  = DATA_CACHE_STORE_DATA_IN;
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    lane_byte_c = 8'(CACHE_RESP_DATA >> {op_addr[1:0], 3'b000});
    lane_half_c = op_addr[1] ? CACHE_RESP_DATA[31:16] : CACHE_RESP_DATA[15:0];
    case (op_load)
      LD_LB:   load_data_c = {{24{lane_byte_c[7]}}, lane_byte_c};
      LD_LH:   load_data_c = {{16{lane_half_c[15]}}, lane_half_c};
      LD_LBU:  load_data_c = {24'd0, lane_byte_c};
      LD_LHU:  load_data_c = {16'd0, lane_half_c};
      default: load_data_c = CACHE_RESP_DATA;
    endcase
    result_c = op_wb_sel ? load_data_c : op_addr;
  end

  // Next-state and next-register logic
  always_comb begin
    state_next      = state;
    op_load_next    = op_load;
    op_write_next   = op_write;
    op_addr_next    = op_addr;
    op_strobe_next  = op_strobe;
    op_data_next    = op_data;
    op_wb_sel_next  = op_wb_sel;
    op_rd_next      = op_rd;
    op_we_next      = op_we;
    rd_address_next = RD_ADDRESS_OUT;
    rd_data_next    = RD_DATA_OUT;
    rd_we_next      = LOW;
    misaligned_next = LOW;
    case (state)
      IDLE: begin
        rd_address_next = RD_ADDRESS_IN;
        rd_data_next    = ALU_OUT_IN;
        if (load_op_c == LD_NONE && store_op_c == ST_NONE) begin
          rd_we_next = RD_WRITE_ENABLE_IN;
        end else if (misaligned_c) begin
          misaligned_next = HIGH;
        end else begin
          op_load_next   = load_op_c;
          op_write_next  = (store_op_c != ST_NONE);
          op_addr_next   = ALU_OUT_IN;
          op_strobe_next = strobe_c;
          op_data_next   = wdata_c;
          op_wb_sel_next = WRITE_BACK_MUX_SELECT_IN;
          op_rd_next     = RD_ADDRESS_IN;
          op_we_next     = RD_WRITE_ENABLE_IN;
          state_next     = REQUEST;
        end
      end
      REQUEST: begin
        if (CACHE_REQ_READY)
          state_next = op_write ? IDLE : WAIT_RESPONSE;
      end
      WAIT_RESPONSE: begin
        if (CACHE_RESP_VALID) begin
          rd_address_next = op_rd;
          rd_data_next    = result_c;
          rd_we_next      = op_we;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and payload registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state                <= IDLE;
      op_load              <= LD_NONE;
      op_write             <= LOW;
      op_addr              <= '0;
      op_strobe            <= '0;
      op_data              <= '0;
      op_wb_sel            <= LOW;
      op_rd                <= '0;
      op_we                <= LOW;
      RD_ADDRESS_OUT       <= '0;
      RD_DATA_OUT          <= '0;
      RD_WRITE_ENABLE_OUT  <= LOW;
      MISALIGNED_EXCEPTION <= LOW;
    end else begin
      state                <= state_next;
      op_load              <= op_load_next;
      op_write             <= op_write_next;
      op_addr              <= op_addr_next;
      op_strobe            <= op_strobe_next;
      op_data              <= op_data_next;
      op_wb_sel            <= op_wb_sel_next;
      op_rd                <= op_rd_next;
      op_we                <= op_we_next;
      RD_ADDRESS_OUT       <= rd_address_next;
      RD_DATA_OUT          <= rd_data_next;
      RD_WRITE_ENABLE_OUT  <= rd_we_next;
      MISALIGNED_EXCEPTION <= misaligned_next;
    end
  end

  // Cache request and stall are decoded from registered state only
  always_comb begin
    CACHE_REQ_VALID    = (state == REQUEST);
    STALL_REQUEST      = (state != IDLE);
    CACHE_REQ_WRITE    = op_write;
    CACHE_ADDRESS      = {op_addr[31:2], 2'b00};
    CACHE_WRITE_STROBE = op_strobe;
    CACHE_WRITE_DATA   = op_data;
  end

endmodule

// File: tb/tb_data_memory_stage.sv
// Randomized bench for data_memory_stage: an execute-stage model that honours
// STALL_REQUEST, a cache model with random ready/response delays, and an
// in-order event scoreboard built from the load/store rules.
module tb_data_memory_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rd_address_in;
  logic [31:0] alu_out_in;
  logic [2:0]  ld_in;
  logic [1:0]  st_in;
  logic [31:0] st_data_in;
  logic        wb_sel_in;
  logic        we_in;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] cache_address;
  logic [3:0]  write_strobe;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        stall;
  logic [4:0]  rd_address_out;
  logic [31:0] rd_data_out;
  logic        rd_we_out;
  logic        misaligned;

  data_memory_stage dut (
    .CLK(clk), .RESETN(resetn),
    .RD_ADDRESS_IN(rd_address_in), .ALU_OUT_IN(alu_out_in),
    .DATA_CACHE_LOAD_IN(ld_in), .DATA_CACHE_STORE_IN(st_in),
    .DATA_CACHE_STORE_DATA_IN(st_data_in),
    .WRITE_BACK_MUX_SELECT_IN(wb_sel_in), .RD_WRITE_ENABLE_IN(we_in),
    .CACHE_REQ_VALID(req_valid), .CACHE_REQ_READY(req_ready),
    .CACHE_REQ_WRITE(req_write), .CACHE_ADDRESS(cache_address),
    .CACHE_WRITE_STROBE(write_strobe), .CACHE_WRITE_DATA(write_data),
    .CACHE_RESP_VALID(resp_valid), .CACHE_RESP_DATA(resp_data),
    .STALL_REQUEST(stall), .RD_ADDRESS_OUT(rd_address_out),
    .RD_DATA_OUT(rd_data_out), .RD_WRITE_ENABLE_OUT(rd_we_out),
    .MISALIGNED_EXCEPTION(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [31:0] resp;
    logic [4:0]  rd;
    logic        we;
    logic        wbsel;
    int          rdy_dly;
    int          resp_dly;
  } instr_t;

  // kind 0 = write-back (a=rd, b=data), 1 = exception, 2 = request (a=addr, b=strobe, c=data)
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        wr;
  } ev_t;

  ev_t    evq[$];
  instr_t dirq[$];
  instr_t bus_instr, mem_op;
  ev_t    obs;
  int     n_checks = 0, n_pass = 0;
  int     exp_stall = 0, stall_cnt = 0, rdy_left = 0, resp_left = 0;
  bit     pending = 0, advance = 1, draining = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic instr_t mk(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] alu,
                                input logic [31:0] sdata, input logic [4:0] rd, input logic we,
                                input int rdy, input int rdl, input logic [31:0] resp);
    instr_t i;
    i.ld = ld; i.st = st; i.alu = alu; i.sdata = sdata; i.rd = rd; i.we = we;
    i.wbsel = 1'b1; i.rdy_dly = rdy; i.resp_dly = rdl; i.resp = resp;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    k = int'($urandom_range(0, 3));
    i = mk(3'd0, 2'd0, $urandom, $urandom, 5'($urandom), ($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
    i.wbsel = 1'($urandom);
    if ($urandom_range(0, 2) != 0) i.alu[1:0] = 2'b00;
    case (k)
      0: if ($urandom_range(0, 3) == 0) i.ld = 3'($urandom_range(6, 7));
      1: i.ld = 3'($urandom_range(1, 5));
      2: begin
        i.st = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) i.ld = 3'($urandom_range(6, 7));
      end
      default: begin
        i.ld = 3'($urandom_range(1, 5));
        i.st = 2'($urandom_range(1, 3));
      end
    endcase
    return i;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 128) ? b - 32'd256 : b;
      3'd2:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Reference model: expected visible events and stall length for one accepted instruction
  function automatic void model_accept(input instr_t i);
    int    ld, st, size;
    ev_t   e;
    ld = (i.ld >= 1 && i.ld <= 5) ? int'(i.ld) : 0;
    st = (ld != 0) ? 0 : int'(i.st);
    size = (ld == 3 || st == 3) ? 4 : (ld == 2 || ld == 5 || st == 2) ? 2 : 1;
    e.a = 0; e.b = 0; e.c = 0; e.wr = 0;
    exp_stall = 0;
    if (ld == 0 && st == 0) begin
      if (i.we) begin e.kind = 0; e.a = 32'(i.rd); e.b = i.alu; evq.push_back(e); end
    end else if (i.alu % size != 0) begin
      e.kind = 1; evq.push_back(e);
    end else begin
      mem_op = i;
      rdy_left = i.rdy_dly;
      e.kind = 2; e.a = i.alu - (i.alu % 4);
      if (st != 0) begin
        e.wr = 1;
        e.b = (st == 1) ? (32'd1 << (i.alu % 4)) : (st == 2) ? (32'd3 << (i.alu % 4)) : 32'd15;
        e.c = (st == 1) ? (i.sdata % 256) * 32'h0101_0101 :
              (st == 2) ? (i.sdata % 65536) * 32'h0001_0001 : i.sdata;
        evq.push_back(e);
        exp_stall = i.rdy_dly + 1;
      end else begin
        evq.push_back(e);
        if (i.we) begin
          e.kind = 0; e.a = 32'(i.rd); e.wr = 0; e.c = 0;
          e.b = i.wbsel ? load_value(3'(ld), i.alu, i.resp) : i.alu;
          evq.push_back(e);
        end
        exp_stall = i.rdy_dly + i.resp_dly + 2;
      end
    end
  endfunction

  task automatic see_event(input string tag, input ev_t got, input bit consume);
    ev_t e;
    if (evq.size() == 0) begin
      check_eq({tag, "_spurious_kind"}, 32'(got.kind), 32'hFFFF_FFFF);
    end else begin
      e = evq[0];
      check_eq({tag, "_kind"}, 32'(got.kind), 32'(e.kind));
      if (got.kind == e.kind && e.kind != 1) begin
        check_eq({tag, "_a"}, got.a, e.a);
        check_eq({tag, "_b"}, got.b, e.b);
        if (e.kind == 2) begin
          check_eq({tag, "_write"}, 32'(got.wr), 32'(e.wr));
          if (e.wr) check_eq({tag, "_data"}, got.c, e.c);
        end
      end
      if (consume) void'(evq.pop_front());
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(req_valid), 0);
    check_eq({tag, "_stall"}, 32'(stall), 0);
    check_eq({tag, "_write"}, 32'(req_write), 0);
    check_eq({tag, "_addr"}, cache_address, 0);
    check_eq({tag, "_strobe"}, 32'(write_strobe), 0);
    check_eq({tag, "_wdata"}, write_data, 0);
    check_eq({tag, "_rd"}, 32'(rd_address_out), 0);
    check_eq({tag, "_rd_data"}, rd_data_out, 0);
    check_eq({tag, "_we"}, 32'(rd_we_out), 0);
    check_eq({tag, "_misaligned"}, 32'(misaligned), 0);
  endtask

  task automatic drive(input instr_t i);
    ld_in = i.ld; st_in = i.st; alu_out_in = i.alu; st_data_in = i.sdata;
    rd_address_in = i.rd; we_in = i.we; wb_sel_in = i.wbsel;
  endtask

  initial begin
    resetn = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    drive(mk(3'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 0, 0, 32'd0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;

    dirq.push_back(mk(3'd0, 2'd0, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 0, 0, 32'd0));
    dirq.push_back(mk(3'd1, 2'd0, 32'h0000_0103, 32'd0, 5'd7, 1'b1, 0, 0, 32'h80AA_BBCC));
    dirq.push_back(mk(3'd4, 2'd0, 32'h0000_0103, 32'd0, 5'd8, 1'b1, 0, 0, 32'h80AA_BBCC));
    dirq.push_back(mk(3'd0, 2'd2, 32'h0000_0202, 32'hDEAD_BEEF, 5'd1, 1'b1, 3, 0, 32'd0));
    dirq.push_back(mk(3'd3, 2'd0, 32'h0000_0301, 32'd0, 5'd2, 1'b1, 0, 0, 32'd0));
    dirq.push_back(mk(3'd3, 2'd0, 32'h0000_0400, 32'd0, 5'd3, 1'b1, 1, 2, 32'hCAFE_F00D));
    dirq.push_back(mk(3'd0, 2'd0, 32'h0000_5555, 32'd0, 5'd9, 1'b1, 0, 0, 32'd0));

    for (int cyc = 0; cyc < 1600; cyc++) begin
      if (cyc == 1500) draining = 1;
      if (rd_we_out) begin
        obs.kind = 0; obs.a = 32'(rd_address_out); obs.b = rd_data_out; obs.c = 0; obs.wr = 0;
        see_event("wb", obs, 1'b1);
      end
      if (misaligned) begin
        obs.kind = 1; obs.a = 0; obs.b = 0; obs.c = 0; obs.wr = 0;
        see_event("exc", obs, 1'b1);
      end
      if (stall) stall_cnt++;
      else begin
        if (stall_cnt != 0) check_eq("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        stall_cnt = 0;
      end
      // cache response side, decided before any new handshake
      resp_valid = 1'b0;
      resp_data = $urandom;
      if (pending) begin
        if (resp_left == 0) begin resp_valid = 1'b1; resp_data = mem_op.resp; pending = 0; end
        else resp_left--;
      end else if (!stall && $urandom_range(0, 3) == 0) begin
        resp_valid = 1'b1;
      end
      // cache request side
      req_ready = 1'($urandom);
      if (req_valid) begin
        obs.kind = 2; obs.a = cache_address; obs.b = 32'(write_strobe);
        obs.c = write_data; obs.wr = req_write;
        if (rdy_left == 0) begin
          req_ready = 1'b1;
          see_event("req", obs, 1'b1);
          if (!obs.wr) begin pending = 1; resp_left = mem_op.resp_dly; end
        end else begin
          req_ready = 1'b0;
          see_event("req_hold", obs, 1'b0);
          rdy_left--;
        end
      end
      if (!stall) check_eq("idle_drained", 32'(evq.size()), 0);
      // execute stage: advances only past an accepted instruction
      if (advance) begin
        if (draining) bus_instr = mk(3'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 0, 0, 32'd0);
        else if (dirq.size() != 0) bus_instr = dirq.pop_front();
        else bus_instr = rand_instr();
        drive(bus_instr);
      end
      if (!stall) begin model_accept(bus_instr); advance = 1; end
      else advance = 0;
      @(negedge clk);
    end
    check_eq("final_drained", 32'(evq.size()), 0);

    // Reset while waiting for a load response; a later response must be ignored
    req_ready = 1'b1; resp_valid = 1'b0;
    drive(mk(3'd3, 2'd0, 32'h0000_0500, 32'd0, 5'd3, 1'b1, 0, 0, 32'd0));
    @(negedge clk);
    check_eq("rst_t_req_valid", 32'(req_valid), 1);
    drive(mk(3'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 0, 0, 32'd0));
    @(negedge clk);
    check_eq("rst_t_wait_stall", 32'(stall), 1);
    check_eq("rst_t_wait_valid", 32'(req_valid), 0);
    resetn = 1'b0; req_ready = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    resetn = 1'b1; resp_valid = 1'b1; resp_data = 32'h1234_5678;
    @(negedge clk);
    resp_valid = 1'b0;
    check_eq("stray_resp_we", 32'(rd_we_out), 0);
    check_eq("stray_resp_data", rd_data_out, 0);
    check_eq("stray_resp_stall", 32'(stall), 0);
    @(negedge clk);
    check_eq("stray_resp_we2", 32'(rd_we_out), 0);
    check_eq("stray_resp_valid2", 32'(req_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
